mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the multiplier width in bits and the number of shift iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one multiplication.
REQ-005 The block SHALL have port lsb, input, 1 bit: bit 0 of the product register (current multiplier bit).
REQ-006 The block SHALL have port RESET, output, 1 bit: loads the multiplier into the register and clears the upper part.
REQ-007 The block SHALL have port ADD, output, 1 bit: loads {carry,sum} into the upper register bits.
REQ-008 The block SHALL have port SHIFT, output, 1 bit: shifts the register right by one bit.
REQ-009 The block SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the product as valid.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, LOAD, EVAL, SHIFT_ST and DONE, plus a shift counter of width $clog2(N+1).
REQ-012 The block SHALL assert ready exactly when the FSM is in IDLE, and SHALL ignore start in every other state.
REQ-013 From IDLE with start=1 at a clock edge, the FSM SHALL go to LOAD and clear the counter.
REQ-014 In LOAD the block SHALL assert RESET for exactly one cycle, then go to EVAL.
REQ-015 In EVAL with lsb=1 the block SHALL assert ADD only, then go to SHIFT_ST.
REQ-016 In EVAL with lsb=0 the block SHALL assert SHIFT only, increment the counter, and go to DONE if the new count equals N, otherwise stay in EVAL.
REQ-017 In SHIFT_ST the block SHALL assert SHIFT only, increment the counter, and go to DONE if the new count equals N, otherwise return to EVAL.
REQ-018 In DONE the block SHALL assert done for exactly one cycle, then go to IDLE; a start sampled in DONE SHALL be ignored.
REQ-019 ADD, SHIFT and RESET SHALL be mutually exclusive in every cycle.
REQ-020 All outputs SHALL be Moore or lsb-decoded only, with no combinational path from start to any output.
REQ-021 Latency: with start sampled at edge E0, RESET SHALL be high from E0 to E1, and done SHALL be high from E(9+p) to E(10+p), where p is the popcount of the multiplier (for N=8).
REQ-022 The counter SHALL never exceed N and SHALL saturate rather than wrap around.
REQ-023 Any unused FSM encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 While reset=1 the FSM SHALL be IDLE, the counter SHALL be 0, RESET/ADD/SHIFT/done SHALL be 0, and ready SHALL be 1, independent of clk.
REQ-025 A reset asserted mid-operation SHALL abort immediately, and the next start after release SHALL begin a complete fresh sequence.

Configuration
REQ-026 When MULT_CTRL_ERR_EN is defined, the block SHALL add output err (1 bit, reset 0) that is set sticky when start=1 while ready=0 and cleared when a start is accepted from IDLE.
REQ-027 When MULT_CTRL_ERR_EN is not defined, the err port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-028 Multiplier 73 (lsb sequence 1,0,0,1,0,0,1,0) with start pulsed at E0 -> RESET at E0-E1; ADD count 3, SHIFT count 8; done high E12-E13; product equals 73*multiplicand.
REQ-029 Multiplier 0 -> no ADD, 8 consecutive SHIFT cycles; done high E9-E10.
REQ-030 Multiplier 255 -> alternating ADD/SHIFT pairs, 8 ADDs total; done high E17-E18.
REQ-031 start held high continuously -> back-to-back operations; exactly one done per operation, with one IDLE cycle between done and the next RESET.
REQ-032 Assert reset during the 4th SHIFT -> all outputs 0 and ready=1 immediately; the next multiplication of 73 completes correctly with done at E12.
REQ-033 With MULT_CTRL_ERR_EN defined, pulse start while busy -> err=1 until the next accepted start, with the sequence unaffected; a checker SHALL flag any cycle in which ADD, SHIFT and RESET overlap.

Source files
------------

// File: rtl/mult_ctrl.sv
// Control FSM for an N-bit shift-and-add multiplier: sequences RESET/ADD/SHIFT and signals ready/done.
// Optional sticky protocol-error flag `err` is built when MULT_CTRL_ERR_EN is defined.
module mult_ctrl #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic lsb,
    output logic RESET,
    output logic ADD,
    output logic SHIFT,
    output logic ready,
`ifdef MULT_CTRL_ERR_EN
    output logic err,
`endif
    output logic done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        EVAL     = 3'd2,
        SHIFT_ST = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          last_shift;

    // Saturating increment: the count holds at N instead of wrapping.
    assign cnt_inc    = (cnt == CW'(N)) ? cnt : cnt + CW'(1);
    assign last_shift = (cnt_inc == CW'(N));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD:     state_next = EVAL;
            EVAL: begin
                if (lsb) begin
                    state_next = SHIFT_ST;
                end else begin
                    cnt_next   = cnt_inc;
                    state_next = last_shift ? DONE : EVAL;
                end
            end
            SHIFT_ST: begin
                cnt_next   = cnt_inc;
                state_next = last_shift ? DONE : EVAL;
            end
            DONE:     state_next = IDLE;
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Moore decode, with lsb selecting ADD versus SHIFT in EVAL; start never reaches an output.
    always_comb begin
        RESET = 1'b0;
        ADD   = 1'b0;
        SHIFT = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:     ready = 1'b1;
            LOAD:     RESET = 1'b1;
            EVAL: begin
                if (lsb) ADD   = 1'b1;
                else     SHIFT = 1'b1;
            end
            SHIFT_ST: SHIFT = 1'b1;
            DONE:     done  = 1'b1;
            default:  ;
        endcase
    end

`ifdef MULT_CTRL_ERR_EN
    // Sticky until the next accepted start; set by any start seen while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start && state == IDLE) begin
            err <= 1'b0;
        end else if (start && !ready) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural product register closes the lsb loop; vectors carry hand-computed
// ADD counts and done edges, plus sequences for held start and mid-operation reset.
module tb_mult_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic lsb;
    logic RESET;
    logic ADD;
    logic SHIFT;
    logic ready;
    logic done;
`ifdef MULT_CTRL_ERR_EN
    logic err;
`endif

    int n_checks    = 0;
    int n_fail      = 0;
    int overlap_cnt = 0;

    logic [2*N:0] prod;

    always #5 clk = ~clk;

    mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lsb   (lsb),
        .RESET (RESET),
        .ADD   (ADD),
        .SHIFT (SHIFT),
        .ready (ready),
`ifdef MULT_CTRL_ERR_EN
        .err   (err),
`endif
        .done  (done)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Datapath controls must never overlap.
    always @(negedge clk) begin
        if ((ADD && SHIFT) || (ADD && RESET) || (SHIFT && RESET)) overlap_cnt++;
    end

    // Behavioural {carry, upper, lower} product register driven by the DUT's controls.
    task automatic apply(input logic a, input logic s, input logic r,
                         input logic [N-1:0] mult, input logic [N-1:0] mcand);
        if (r)      prod = {{(N+1){1'b0}}, mult};
        else if (a) prod[2*N:N] = {1'b0, prod[2*N-1:N]} + {1'b0, mcand};
        else if (s) prod = prod >> 1;
        lsb = prod[0];
    endtask

    typedef struct {
        logic [N-1:0] mult;
        logic [N-1:0] mcand;
        int           adds;
        int           done_edge;
        int           poke_cyc;
        bit           poke_done;
    } vec_t;

    vec_t vecs [6];

    task automatic run_op(input logic [N-1:0] mult, input logic [N-1:0] mcand, input int exp_adds,
                          input int exp_done_edge, input int poke_cyc, input bit poke_done,
                          input string tag);
        int          adds      = 0;
        int          shifts    = 0;
        int          resets    = 0;
        int          done_edge = -1;
        bit          fin       = 1'b0;
        bit          poked     = 1'b0;
        logic        a, s, r, d;
        logic [31:0] exp_prod;
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(ready), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            a = ADD; s = SHIFT; r = RESET; d = done;
            if (cyc == 0) begin
                check({tag, ".reset_at_e0"}, 32'(r), 32'd1);
                check({tag, ".busy_not_ready"}, 32'(ready), 32'd0);
`ifdef MULT_CTRL_ERR_EN
                check({tag, ".err_cleared"}, 32'(err), 32'd0);
`endif
            end
            if (a) adds++;
            if (s) shifts++;
            if (r) resets++;
            if (d) begin
                done_edge = cyc;
                fin       = 1'b1;
            end
            if (cyc == poke_cyc || (d && poke_done)) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            apply(a, s, r, mult, mcand);
        end
        check({tag, ".done_seen"}, 32'(fin), 32'd1);
        check({tag, ".done_edge"}, done_edge, exp_done_edge);
        check({tag, ".add_count"}, adds, exp_adds);
        check({tag, ".shift_count"}, shifts, N);
        check({tag, ".reset_count"}, resets, 32'd1);
        exp_prod = 32'(mult) * 32'(mcand);
        check({tag, ".product"}, {16'b0, prod[2*N-1:0]}, exp_prod);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".idle_after_done"}, 32'(ready), 32'd1);
        check({tag, ".no_restart"}, 32'(RESET), 32'd0);
`ifdef MULT_CTRL_ERR_EN
        check({tag, ".err_sticky"}, 32'(err), 32'(poked));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".RESET"}, 32'(RESET), 32'd0);
        check({tag, ".ADD"},   32'(ADD),   32'd0);
        check({tag, ".SHIFT"}, 32'(SHIFT), 32'd0);
        check({tag, ".done"},  32'(done),  32'd0);
        check({tag, ".ready"}, 32'(ready), 32'd1);
`ifdef MULT_CTRL_ERR_EN
        check({tag, ".err"},   32'(err),   32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic a, s, r, d;
        logic rdy_hist [30];
        logic rst_hist [30];
        logic done_hist [30];
        int   dones;
        int   resets;
        int   shifts;
        bit   hit;

        //          mult      mcand  adds edge poke done-poke
        vecs[0] = '{8'd73,  8'd5,   3, 12, -1, 1'b0};
        vecs[1] = '{8'd0,   8'd200, 0,  9, -1, 1'b0};
        vecs[2] = '{8'd255, 8'd255, 8, 17, -1, 1'b0};
        vecs[3] = '{8'd170, 8'd3,   4, 13,  4, 1'b0};
        vecs[4] = '{8'd128, 8'd9,   1, 10, -1, 1'b1};
        vecs[5] = '{8'd1,   8'd77,  1, 10, -1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        lsb   = 1'b0;
        prod  = '0;
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].mult, vecs[i].mcand, vecs[i].adds, vecs[i].done_edge,
                   vecs[i].poke_cyc, vecs[i].poke_done, $sformatf("vec%0d", i));
        end

        // start held high with multiplier 0: operations run back to back.
        dones  = 0;
        resets = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            a = ADD; s = SHIFT; r = RESET; d = done;
            rdy_hist[cyc]  = ready;
            rst_hist[cyc]  = r;
            done_hist[cyc] = d;
            if (r) resets++;
            if (d) dones++;
            @(posedge clk);
            #1 apply(a, s, r, 8'd0, 8'd0);
        end
        start = 1'b0;
        check("held.done_count", dones, 32'd2);
        check("held.reset_count", resets, 32'd3);
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (done_hist[cyc]) begin
                check($sformatf("held.idle_gap_%0d", cyc), 32'(rdy_hist[cyc+1]), 32'd1);
                check($sformatf("held.reload_%0d", cyc), 32'(rst_hist[cyc+2]), 32'd1);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check_reset_outputs("held_abort");
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted during the 4th SHIFT of a 73 multiplication.
        shifts = 0;
        hit    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
            @(negedge clk);
            a = ADD; s = SHIFT; r = RESET;
            if (s) shifts++;
            if (shifts == 4) begin
                #2 reset = 1'b1;
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1 apply(a, s, r, 8'd73, 8'd11);
            end
        end
        check("abort.reached_4th_shift", 32'(hit), 32'd1);
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 check("abort.held_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op(8'd73, 8'd11, 3, 12, -1, 1'b0, "after_abort");

        check("no_ctrl_overlap", overlap_cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
